// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM-subset control unit: opcode/condition enums,
// datapath select codes, controller FSM states and the condition evaluator.
package arm_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_NOP = 2'b11
  } op_e;

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_e;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrl_state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] REGSRC_DP  = 2'b00;
  localparam logic [1:0] REGSRC_BR  = 2'b01;
  localparam logic [1:0] REGSRC_STR = 2'b10;

  // flags = {N,Z,C,V}
  function automatic logic cond_eval(input cond_e c, input logic [3:0] flags);
    logic n, z, cf, v;
    {n, z, cf, v} = flags;
    case (c)
      C_EQ:    return z;
      C_NE:    return ~z;
      C_CS:    return cf;
      C_CC:    return ~cf;
      C_MI:    return n;
      C_PL:    return ~n;
      C_VS:    return v;
      C_VC:    return ~v;
      C_HI:    return cf & ~z;
      C_LS:    return ~cf | z;
      C_GE:    return n == v;
      C_LT:    return n != v;
      C_GT:    return ~z & (n == v);
      C_LE:    return z | (n != v);
      C_AL:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm_controller_if.sv
// Controller <-> datapath/memory signal bundle; the controller drives through
// the master modport, the datapath side sees the slave view.
interface arm_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        mem_ready;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [1:0]  ImmSrc;
  logic        ALUSrc;
  logic [1:0]  ALUControl;
  logic        MemtoReg;
  logic        PCSrc;
  logic        MemWrite;
  logic        mem_req;
  logic        pc_stall;
  logic [3:0]  flags_q;
  logic        mem_err;

  modport master (
    input  Instr, ALUFlags, mem_ready,
    output RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
           MemWrite, mem_req, pc_stall, flags_q, mem_err
  );

  modport slave (
    output Instr, ALUFlags, mem_ready,
    input  RegSrc, RegWrite, ImmSrc, ALUSrc, ALUControl, MemtoReg, PCSrc,
           MemWrite, mem_req, pc_stall, flags_q, mem_err
  );
endinterface

// File: rtl/arm_controller_cond_logic.sv
// Architectural NZCV register, condition evaluation and gating of the
// state-changing enables by condition, stall and abort.
module cond_logic
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       PCS,
  input  logic       pc_stall,
  input  logic       abort,
  output logic       CondEx,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCSrc,
  output logic [3:0] flags_q
);

  logic [3:0] flags_d;
  logic       issue;

  // Evaluated against the pre-update flags so an S-instruction sees old NZCV.
  assign CondEx = cond_eval(cond_e'(cond), flags_q);
  assign issue  = CondEx & ~pc_stall & ~abort;

  assign RegWrite = RegW & issue;
  assign PCSrc    = PCS & issue;
  // The store strobe stays up while the memory handshake is pending.
  assign MemWrite = MemW & CondEx & ~abort;

  always_comb begin
    flags_d = flags_q;
    if (FlagW[1] & issue) flags_d[3:2] = ALUFlags[3:2];
    if (FlagW[0] & issue) flags_d[1:0] = ALUFlags[1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

endmodule

// File: rtl/arm_controller.sv
// Single-cycle ARM-subset control unit: instruction decode plus a RUN/WAIT
// FSM that stalls the PC on load/store until mem_ready or timeout.
module arm_controller
  import arm_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  arm_controller_if.master bus
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] CNT_MAX = TW'(MEM_TIMEOUT);

  op_e        op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] unused_rn;
  logic       reg_w, mem_w, branch, pcs, is_mem, alu_src, mem_to_reg;
  logic [1:0] flag_w, alu_ctl, imm_src, reg_src;

  assign op        = op_e'(bus.Instr[15:14]);
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = bus.Instr[7:4];

  always_comb begin
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    is_mem     = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    flag_w     = 2'b00;
    alu_ctl    = ALU_ADD;
    imm_src    = IMM_DP;
    reg_src    = REGSRC_DP;
    case (op)
      OP_DP: begin
        reg_w   = 1'b1;
        alu_src = funct[5];
        case (funct[4:1])
          4'b0100: alu_ctl = ALU_ADD;
          4'b0010: alu_ctl = ALU_SUB;
          4'b0000: alu_ctl = ALU_AND;
          4'b1100: alu_ctl = ALU_ORR;
          default: reg_w   = 1'b0;
        endcase
        flag_w[1] = funct[0];
        flag_w[0] = funct[0] & ((funct[4:1] == 4'b0100) | (funct[4:1] == 4'b0010));
      end
      OP_MEM: begin
        is_mem  = 1'b1;
        alu_src = 1'b1;
        imm_src = IMM_MEM;
        if (funct[0]) begin
          reg_w      = 1'b1;
          mem_to_reg = 1'b1;
        end else begin
          mem_w   = 1'b1;
          reg_src = REGSRC_STR;
        end
      end
      OP_BR: begin
        branch  = 1'b1;
        alu_src = 1'b1;
        imm_src = IMM_BR;
        reg_src = REGSRC_BR;
      end
      default: ;
    endcase
  end

  assign pcs = branch | ((rd == 4'hF) & reg_w);

  ctrl_state_e   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;
  logic          cond_ex, mem_req, abort, pc_stall;

  assign mem_req  = is_mem & cond_ex;
  assign abort    = (state_q == WAIT) & mem_req & (cnt_q == CNT_MAX) & ~bus.mem_ready;
  // Held low while reset is asserted so a reset mid-wait releases the PC at once.
  assign pc_stall = reset & mem_req & ~bus.mem_ready & ~abort;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q | abort;
    case (state_q)
      RUN: begin
        if (mem_req & ~bus.mem_ready) begin
          state_d = WAIT;
          cnt_d   = TW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT: begin
        if (!mem_req || bus.mem_ready) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  logic       reg_write, mem_write, pc_src;
  logic [3:0] flags;

  cond_logic u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (bus.Instr[19:16]),
    .ALUFlags (bus.ALUFlags),
    .FlagW    (flag_w),
    .RegW     (reg_w),
    .MemW     (mem_w),
    .PCS      (pcs),
    .pc_stall (pc_stall),
    .abort    (abort),
    .CondEx   (cond_ex),
    .RegWrite (reg_write),
    .MemWrite (mem_write),
    .PCSrc    (pc_src),
    .flags_q  (flags)
  );

  assign bus.RegSrc     = reg_src;
  assign bus.RegWrite   = reg_write;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUSrc     = alu_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.MemtoReg   = mem_to_reg;
  assign bus.PCSrc      = pc_src;
  assign bus.MemWrite   = mem_write;
  assign bus.mem_req    = mem_req;
  assign bus.pc_stall   = pc_stall;
  assign bus.flags_q    = flags;
  assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_arm_controller.sv
// Directed bench for arm_controller: decode, condition gating, flag update,
// load/store wait and timeout, and asynchronous reset in the middle of a wait.
module tb_arm_controller;
  import arm_ctrl_pkg::*;

  localparam logic [19:0] I_ADDS   = 20'hE0921;
  localparam logic [19:0] I_BEQ    = 20'h0A000;
  localparam logic [19:0] I_LDR    = 20'hE5954;
  localparam logic [19:0] I_STR    = 20'hE5854;
  localparam logic [19:0] I_ADDPC  = 20'hE080F;
  localparam logic [19:0] I_ADDNV  = 20'hF080F;
  localparam logic [19:0] I_STRNV  = 20'hF5854;
  localparam logic [19:0] I_NOP    = 20'hEC000;
  localparam logic [19:0] I_ANDS   = 20'hE0101;
  localparam logic [19:0] I_ADDSNE = 20'h10921;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  arm_controller_if bus ();

  arm_controller #(.MEM_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.Instr = I_ADDS; bus.ALUFlags = 4'b0000; bus.mem_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.flags_q !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", bus.flags_q); end
    checks++; if (bus.mem_err !== 1'b0) begin failures++; $display("FAIL reset_mem_err got=%b exp=0", bus.mem_err); end
    checks++; if (bus.pc_stall !== 1'b0) begin failures++; $display("FAIL reset_pc_stall got=%b exp=0", bus.pc_stall); end
    checks++; if (bus.RegWrite !== 1'b1) begin failures++; $display("FAIL reset_decode_regwrite got=%b exp=1", bus.RegWrite); end
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic test_adds();
    bus.Instr = I_ADDS; bus.ALUFlags = 4'b0110;
    @(negedge clk);
    checks++; if (bus.RegWrite !== 1'b1) begin failures++; $display("FAIL adds_regwrite got=%b exp=1", bus.RegWrite); end
    checks++; if (bus.ALUControl !== 2'b00) begin failures++; $display("FAIL adds_aluctl got=%b exp=00", bus.ALUControl); end
    checks++; if (bus.ALUSrc !== 1'b0) begin failures++; $display("FAIL adds_alusrc got=%b exp=0", bus.ALUSrc); end
    checks++; if (bus.PCSrc !== 1'b0 || bus.MemWrite !== 1'b0 || bus.mem_req !== 1'b0) begin failures++; $display("FAIL adds_other_en got=%b%b%b exp=000", bus.PCSrc, bus.MemWrite, bus.mem_req); end
    step();
    bus.Instr = I_NOP; bus.ALUFlags = 4'b0000;
    @(negedge clk);
    checks++; if (bus.flags_q !== 4'b0110) begin failures++; $display("FAIL adds_flags got=%b exp=0110", bus.flags_q); end
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL nop_regwrite got=%b exp=0", bus.RegWrite); end
  endtask

  task automatic test_beq();
    step();
    bus.Instr = I_BEQ;
    @(negedge clk);
    checks++; if (bus.PCSrc !== 1'b1) begin failures++; $display("FAIL beq_taken_pcsrc got=%b exp=1", bus.PCSrc); end
    checks++; if (bus.ImmSrc !== 2'b10) begin failures++; $display("FAIL beq_immsrc got=%b exp=10", bus.ImmSrc); end
    checks++; if (bus.RegSrc !== 2'b01) begin failures++; $display("FAIL beq_regsrc got=%b exp=01", bus.RegSrc); end
    checks++; if (bus.RegWrite !== 1'b0 || bus.ALUSrc !== 1'b1) begin failures++; $display("FAIL beq_regw_alusrc got=%b%b exp=01", bus.RegWrite, bus.ALUSrc); end
    step();
    bus.Instr = I_ADDS; bus.ALUFlags = 4'b0000;
    step();
    bus.Instr = I_BEQ;
    @(negedge clk);
    checks++; if (bus.flags_q !== 4'b0000) begin failures++; $display("FAIL beq_flags_cleared got=%b exp=0000", bus.flags_q); end
    checks++; if (bus.PCSrc !== 1'b0 || bus.RegWrite !== 1'b0) begin failures++; $display("FAIL beq_not_taken got=%b%b exp=00", bus.PCSrc, bus.RegWrite); end
  endtask

  task automatic test_dp_ops();
    logic [19:0] ins [4] = '{20'hE0401, 20'hE0001, 20'hE1801, 20'hE1E01};
    logic [1:0]  ctl [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic        rw  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step();
      bus.Instr = ins[i];
      @(negedge clk);
      checks++; if (bus.ALUControl !== ctl[i] || bus.RegWrite !== rw[i]) begin failures++; $display("FAIL dp_op%0d got ctl=%b rw=%b exp ctl=%b rw=%b", i, bus.ALUControl, bus.RegWrite, ctl[i], rw[i]); end
    end
    step();
    bus.Instr = I_ANDS; bus.ALUFlags = 4'b1111;
    step();
    bus.Instr = I_ADDSNE; bus.ALUFlags = 4'b0011;
    @(negedge clk);
    checks++; if (bus.flags_q !== 4'b1100) begin failures++; $display("FAIL ands_nz_only got=%b exp=1100", bus.flags_q); end
    checks++; if (bus.RegWrite !== 1'b0) begin failures++; $display("FAIL addsne_regwrite got=%b exp=0", bus.RegWrite); end
    step();
    bus.Instr = I_NOP; bus.ALUFlags = 4'b0000;
    @(negedge clk);
    checks++; if (bus.flags_q !== 4'b1100) begin failures++; $display("FAIL addsne_flags_held got=%b exp=1100", bus.flags_q); end
  endtask

  task automatic test_ldr_wait();
    step();
    bus.Instr = I_LDR; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.pc_stall !== 1'b1 || bus.RegWrite !== 1'b0 || bus.mem_req !== 1'b1) begin failures++; $display("FAIL ldr_wait%0d got stall=%b rw=%b req=%b exp 1 0 1", i, bus.pc_stall, bus.RegWrite, bus.mem_req); end
      step();
    end
    bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.pc_stall !== 1'b0 || bus.RegWrite !== 1'b1 || bus.MemtoReg !== 1'b1) begin failures++; $display("FAIL ldr_retire got stall=%b rw=%b m2r=%b exp 0 1 1", bus.pc_stall, bus.RegWrite, bus.MemtoReg); end
    step();
    @(negedge clk);
    checks++; if (bus.pc_stall !== 1'b0 || bus.RegWrite !== 1'b1) begin failures++; $display("FAIL ldr_back_to_back got stall=%b rw=%b exp 0 1", bus.pc_stall, bus.RegWrite); end
  endtask

  task automatic test_str_timeout();
    step();
    bus.Instr = I_STR; bus.mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++; if (bus.pc_stall !== 1'b1 || bus.MemWrite !== 1'b1 || bus.mem_err !== 1'b0) begin failures++; $display("FAIL str_wait%0d got stall=%b mw=%b err=%b exp 1 1 0", i, bus.pc_stall, bus.MemWrite, bus.mem_err); end
      step();
    end
    @(negedge clk);
    checks++; if (bus.pc_stall !== 1'b0 || bus.MemWrite !== 1'b0 || bus.RegWrite !== 1'b0 || bus.PCSrc !== 1'b0) begin failures++; $display("FAIL str_abort got stall=%b mw=%b rw=%b pcs=%b exp 0 0 0 0", bus.pc_stall, bus.MemWrite, bus.RegWrite, bus.PCSrc); end
    step();
    bus.Instr = I_NOP;
    @(negedge clk);
    checks++; if (bus.mem_err !== 1'b1 || bus.pc_stall !== 1'b0) begin failures++; $display("FAIL str_mem_err got err=%b stall=%b exp 1 0", bus.mem_err, bus.pc_stall); end
    step();
    bus.Instr = I_STR;
    @(negedge clk);
    checks++; if (bus.pc_stall !== 1'b1 || bus.MemWrite !== 1'b1 || bus.mem_err !== 1'b1) begin failures++; $display("FAIL str_after_abort got stall=%b mw=%b err=%b exp 1 1 1", bus.pc_stall, bus.MemWrite, bus.mem_err); end
  endtask

  task automatic test_reset_in_wait();
    step();
    step();
    @(negedge clk);
    checks++; if (bus.pc_stall !== 1'b1 || bus.flags_q !== 4'b1100) begin failures++; $display("FAIL prereset_wait got stall=%b flags=%b exp 1 1100", bus.pc_stall, bus.flags_q); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.pc_stall !== 1'b0 || bus.flags_q !== 4'b0000 || bus.mem_err !== 1'b0) begin failures++; $display("FAIL reset_in_wait got stall=%b flags=%b err=%b exp 0 0000 0", bus.pc_stall, bus.flags_q, bus.mem_err); end
    @(posedge clk);
    #1 reset = 1'b1; bus.Instr = I_NOP;
    @(negedge clk);
    checks++; if (bus.mem_err !== 1'b0 || bus.pc_stall !== 1'b0) begin failures++; $display("FAIL post_reset got err=%b stall=%b exp 0 0", bus.mem_err, bus.pc_stall); end
    step();
    bus.Instr = I_STR; bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.MemWrite !== 1'b1 || bus.pc_stall !== 1'b0) begin failures++; $display("FAIL str_ready_now got mw=%b stall=%b exp 1 0", bus.MemWrite, bus.pc_stall); end
  endtask

  task automatic test_pc_write();
    step();
    bus.Instr = I_ADDPC; bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.PCSrc !== 1'b1 || bus.RegWrite !== 1'b1 || bus.mem_req !== 1'b0 || bus.pc_stall !== 1'b0) begin failures++; $display("FAIL add_pc got pcs=%b rw=%b req=%b stall=%b exp 1 1 0 0", bus.PCSrc, bus.RegWrite, bus.mem_req, bus.pc_stall); end
    step();
    bus.Instr = I_ADDNV;
    @(negedge clk);
    checks++; if (bus.PCSrc !== 1'b0 || bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin failures++; $display("FAIL add_nv got pcs=%b rw=%b mw=%b exp 0 0 0", bus.PCSrc, bus.RegWrite, bus.MemWrite); end
    step();
    bus.Instr = I_STRNV; bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.MemWrite !== 1'b0 || bus.mem_req !== 1'b0 || bus.pc_stall !== 1'b0) begin failures++; $display("FAIL str_nv got mw=%b req=%b stall=%b exp 0 0 0", bus.MemWrite, bus.mem_req, bus.pc_stall); end
  endtask

  initial begin
    test_reset();
    test_adds();
    test_beq();
    test_dp_ops();
    test_ldr_wait();
    test_str_timeout();
    test_reset_in_wait();
    test_pc_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
